cdb_rr_mux: RTL and testbench



---
 rtl/cdb_rr_mux.sv | 112 +++++++++++
 tb/tb_cdb_rr_mux.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cdb_rr_mux.sv
// -----------------------------------------------------------------------------
// cdb_rr_mux
//
// Registered, round-robin arbitrated N-channel multiplexer for the common data
// bus. Each functional unit offers a valid/ready result stream. One result per
// cycle is selected, captured in a single output register and presented on the
// CDB with its tag and the index of the producing channel.
//
// Ports:
//   clk          core clock, all state updates on the rising edge
//   rst          synchronous, active-high reset
//   flush_i      pipeline flush, kills the registered result
//   in_valid_i   per-channel result valid
//   in_data_i    channel i data at [i*WIDTH +: WIDTH]
//   in_tag_i     channel i tag at [i*TAG_W +: TAG_W]
//   in_ready_o   per-channel accept, one-hot or zero
//   out_valid_o  CDB result valid
//   out_data_o   CDB result data
//   out_tag_o    CDB result tag
//   out_src_o    index of the channel that produced the current result
//   out_ready_i  CDB consumer accepts the current result
// -----------------------------------------------------------------------------
module cdb_rr_mux #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 6,
    parameter int N_CH  = 4,
    // Derived; not meant to be overridden.
    parameter int SRC_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic [N_CH-1:0]        in_valid_i,
    input  logic [N_CH*WIDTH-1:0]  in_data_i,
    input  logic [N_CH*TAG_W-1:0]  in_tag_i,
    output logic [N_CH-1:0]        in_ready_o,
    output logic                   out_valid_o,
    output logic [WIDTH-1:0]       out_data_o,
    output logic [TAG_W-1:0]       out_tag_o,
    output logic [SRC_W-1:0]       out_src_o,
    input  logic                   out_ready_i
);

    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] grant_idx;
    logic             grant_found;
    logic             load_en;
    logic [SRC_W:0]   scan_sum;
    logic [SRC_W-1:0] scan_idx;
    logic [SRC_W-1:0] next_ptr;

    // The output register can take a new result when it is empty or being
    // consumed this cycle. Reset is folded in so no producer is acked while
    // the register is being cleared.
    assign load_en = (!out_valid_o || out_ready_i) && !flush_i && !rst;

    // Rotating priority search: first valid channel at or after rr_ptr,
    // wrapping modulo N_CH. The sum is one bit wider so non-power-of-two
    // channel counts wrap correctly.
    always_comb begin
        // NOTE: every variable written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_sum    = '0;
        scan_idx    = '0;
        for (int k = 0; k < N_CH; k++) begin
            scan_sum = {1'b0, rr_ptr} + (SRC_W+1)'(k);
            if (scan_sum >= (SRC_W+1)'(N_CH))
                scan_sum = scan_sum - (SRC_W+1)'(N_CH);
            scan_idx = scan_sum[SRC_W-1:0];
            if (!grant_found && in_valid_i[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        in_ready_o = '0;
        if (grant_found && load_en)
            in_ready_o[grant_idx] = 1'b1;
    end

    assign next_ptr = (grant_idx == SRC_W'(N_CH - 1)) ? '0 : grant_idx + SRC_W'(1);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_tag_o   <= '0;
            out_src_o   <= '0;
            rr_ptr      <= '0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (load_en) begin
            if (grant_found) begin
                out_valid_o <= 1'b1;
                out_data_o  <= in_data_i[int'(grant_idx)*WIDTH +: WIDTH];
                out_tag_o   <= in_tag_i[int'(grant_idx)*TAG_W +: TAG_W];
                out_src_o   <= grant_idx;
                rr_ptr      <= next_ptr;
            end else begin
                // Drain without refill: payload holds, only valid drops.
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_rr_mux.sv
// -----------------------------------------------------------------------------
// tb_cdb_rr_mux
//
// Directed scenarios followed by randomized traffic for cdb_rr_mux (N_CH=4).
// A behavioural reference model tracks the output register and the round-robin
// pointer and predicts in_ready_o before each edge and the outputs after it.
// -----------------------------------------------------------------------------
module tb_cdb_rr_mux;

    localparam int WIDTH = 32;
    localparam int TAG_W = 6;
    localparam int N_CH  = 4;
    localparam int SRC_W = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  flush_i;
    logic [N_CH-1:0]       in_valid_i;
    logic [N_CH*WIDTH-1:0] in_data_i;
    logic [N_CH*TAG_W-1:0] in_tag_i;
    logic [N_CH-1:0]       in_ready_o;
    logic                  out_valid_o;
    logic [WIDTH-1:0]      out_data_o;
    logic [TAG_W-1:0]      out_tag_o;
    logic [SRC_W-1:0]      out_src_o;
    logic                  out_ready_i;

    cdb_rr_mux #(.WIDTH(WIDTH), .TAG_W(TAG_W), .N_CH(N_CH)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_tag_i    (in_tag_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_tag_o   (out_tag_o),
        .out_src_o   (out_src_o),
        .out_ready_i (out_ready_i)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Per-channel payloads; packed onto the buses at each step.
    logic [WIDTH-1:0] ch_data [N_CH];
    logic [TAG_W-1:0] ch_tag  [N_CH];

    // Reference model state.
    bit               m_valid;
    logic [WIDTH-1:0] m_data;
    logic [TAG_W-1:0] m_tag;
    int               m_src;
    int               m_ptr;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Winner under the rotating-priority rule, -1 if nobody is valid.
    function automatic int model_winner(input logic [N_CH-1:0] v);
        for (int k = 0; k < N_CH; k++)
            if (v[(m_ptr + k) % N_CH]) return (m_ptr + k) % N_CH;
        return -1;
    endfunction

    // One clock: apply inputs, check in_ready_o before the edge, advance the
    // model at the edge, check registered outputs just after it.
    task automatic step(input bit r, input bit f, input logic [N_CH-1:0] v, input bit ordy);
        logic [N_CH-1:0] exp_rdy;
        int              g;
        bit              can_load;
        rst         = r;
        flush_i     = f;
        in_valid_i  = v;
        out_ready_i = ordy;
        for (int i = 0; i < N_CH; i++) begin
            in_data_i[i*WIDTH +: WIDTH] = ch_data[i];
            in_tag_i[i*TAG_W +: TAG_W]  = ch_tag[i];
        end
        #1;
        can_load = !r && !f && (!m_valid || ordy);
        g        = model_winner(v);
        exp_rdy  = '0;
        if (can_load && g >= 0) exp_rdy[g] = 1'b1;
        check("in_ready", 64'(in_ready_o), 64'(exp_rdy));

        @(posedge clk);
        if (r) begin
            m_valid = 0; m_data = '0; m_tag = '0; m_src = 0; m_ptr = 0;
        end else if (f) begin
            m_valid = 0;
        end else if (can_load) begin
            if (g >= 0) begin
                m_valid = 1;
                m_data  = ch_data[g];
                m_tag   = ch_tag[g];
                m_src   = g;
                m_ptr   = (g + 1) % N_CH;
            end else begin
                m_valid = 0;
            end
        end
        #1;
        check("out_valid", 64'(out_valid_o), 64'(m_valid));
        check("out_data",  64'(out_data_o),  64'(m_data));
        check("out_tag",   64'(out_tag_o),   64'(m_tag));
        check("out_src",   64'(out_src_o),   64'(m_src));
        @(negedge clk);
    endtask

    initial begin
        int exp_seq [6];
        exp_seq = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < N_CH; i++) begin
            ch_data[i] = 32'h1000_0000 * (i + 1) + 32'(i);
            ch_tag[i]  = 6'(10 + i);
        end
        m_valid = 0; m_data = '0; m_tag = '0; m_src = 0; m_ptr = 0;
        rst = 1; flush_i = 0; in_valid_i = '0; out_ready_i = 0;
        in_data_i = '0; in_tag_i = '0;
        @(negedge clk);

        // Reset held two cycles; outputs cleared.
        step(1, 0, 4'b0000, 0);
        step(1, 0, 4'b1111, 1);
        check("reset_valid", 64'(out_valid_o), 64'd0);

        // 1. Single channel: ch2 accepted, registered one cycle later.
        ch_data[2] = 32'hDEAD_BEEF;
        ch_tag[2]  = 6'd5;
        step(0, 0, 4'b0100, 1);
        check("t1_data", 64'(out_data_o), 64'hDEAD_BEEF);
        check("t1_tag",  64'(out_tag_o),  64'd5);
        check("t1_src",  64'(out_src_o),  64'd2);

        // Bring rr_ptr back to 0 via ch3.
        step(0, 0, 4'b1000, 1);

        // 2. All channels busy: 0,1,2,3,0,1 with no bubble.
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 4'b1111, 1);
            check("t2_src", 64'(out_src_o), 64'(exp_seq[i]));
            check("t2_valid", 64'(out_valid_o), 64'd1);
        end

        // 3. Backpressure holding ch1's result, then ch3 before ch0.
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 4'b1001, 0);
            check("t3_hold_src", 64'(out_src_o), 64'd1);
        end
        step(0, 0, 4'b1001, 1);
        check("t3_first", 64'(out_src_o), 64'd3);
        step(0, 0, 4'b1001, 1);
        check("t3_second", 64'(out_src_o), 64'd0);

        // 4. Wrap-around: move rr_ptr to 3, then ch3 wins and ch0 follows.
        step(0, 0, 4'b0100, 1);
        step(0, 0, 4'b1001, 1);
        check("t4_first", 64'(out_src_o), 64'd3);
        step(0, 0, 4'b1001, 1);
        check("t4_second", 64'(out_src_o), 64'd0);

        // 5. Flush while stalled with ch2 pending; ch2 granted afterwards.
        step(0, 0, 4'b0100, 0);
        step(0, 1, 4'b0100, 0);
        check("t5_flushed", 64'(out_valid_o), 64'd0);
        step(0, 0, 4'b0100, 0);
        check("t5_src", 64'(out_src_o), 64'd2);

        // 6. Reset mid-stall discards the held result; ch1 wins after release.
        step(0, 0, 4'b0010, 0);
        step(1, 0, 4'b0010, 0);
        check("t6_data_cleared", 64'(out_data_o), 64'd0);
        step(0, 0, 4'b0010, 1);
        check("t6_src", 64'(out_src_o), 64'd1);

        // Drain without refill: valid drops, payload holds.
        step(0, 0, 4'b0000, 1);
        check("drain_src", 64'(out_src_o), 64'd1);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N_CH; i++) begin
                ch_data[i] = $urandom;
                ch_tag[i]  = 6'($urandom);
            end
            step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 19) == 0,
                 4'($urandom),
                 $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
